// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sdram_arbiter
// Purpose  : Fixed-priority arbiter (refresh > video > CPU) in front of a
//            single-command SDRAM controller, with periodic refresh timer.
// Revision : 1.0 - initial release
// ============================================================================
module sdram_arbiter #(
    parameter logic [15:0] REFRESH_PERIOD = 16'd1000,
    parameter int          AW             = 24
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    output logic [15:0]   p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [15:0]   p1_wdata,
    output logic          p1_ack,
    output logic [15:0]   p1_rdata,
    output logic [AW-1:0] ctl_addr,
    output logic [15:0]   ctl_din,
    output logic          ctl_read_rq,
    output logic          ctl_write_rq,
    output logic          ctl_rfsh_rq,
    input  logic [15:0]   ctl_dout,
    input  logic          ctl_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [1:0] c_JOB_RFSH = 2'd0;
    localparam logic [1:0] c_JOB_P0   = 2'd1;
    localparam logic [1:0] c_JOB_P1   = 2'd2;

    state_t        r_state;
    logic [1:0]    r_job;
    logic          r_we;
    logic [15:0]   r_timer;
    logic [1:0]    r_rfsh_cnt;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_din;
    logic [15:0]   r_p0_rdata;
    logic [15:0]   r_p1_rdata;
    logic          r_read_rq;
    logic          r_write_rq;
    logic          r_rfsh_rq;
    logic          r_p0_ack;
    logic          r_p1_ack;

    logic          w_tick;
    logic          w_rfsh_pend;
    logic          w_p0_pend;
    logic          w_p1_pend;
    logic          w_grant;
    logic          w_rfsh_done;

    // A port's request is still high during its own ack cycle; mask it so
    // the finished access is not granted a second time.
    assign w_p0_pend   = p0_req && !r_p0_ack;
    assign w_p1_pend   = p1_req && !r_p1_ack;
    assign w_rfsh_pend = (r_rfsh_cnt != 2'd0);
    assign w_tick      = (r_timer == 16'd0);
    assign w_grant     = (r_state == S_IDLE) && !ctl_busy &&
                         (w_rfsh_pend || w_p0_pend || w_p1_pend);
    assign w_rfsh_done = (r_state == S_WAIT_DONE) && !ctl_busy &&
                         (r_job == c_JOB_RFSH);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_timer <= REFRESH_PERIOD - 16'd1;
        end else if (w_tick) begin
            r_timer <= REFRESH_PERIOD - 16'd1;
        end else begin
            r_timer <= r_timer - 16'd1;
        end
    end

    // Pending refreshes are retired on completion; a tick landing in the
    // same cycle cancels the decrement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rfsh_cnt <= 2'd0;
        end else if (w_tick && !w_rfsh_done) begin
            if (r_rfsh_cnt != 2'd3) begin
                r_rfsh_cnt <= r_rfsh_cnt + 2'd1;
            end
        end else if (!w_tick && w_rfsh_done) begin
            r_rfsh_cnt <= r_rfsh_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_job      <= c_JOB_RFSH;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_din      <= 16'd0;
            r_p0_rdata <= 16'd0;
            r_p1_rdata <= 16'd0;
            r_read_rq  <= 1'b0;
            r_write_rq <= 1'b0;
            r_rfsh_rq  <= 1'b0;
            r_p0_ack   <= 1'b0;
            r_p1_ack   <= 1'b0;
        end else begin
            r_p0_ack <= 1'b0;
            r_p1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state <= S_ISSUE;
                        if (w_rfsh_pend) begin
                            r_job     <= c_JOB_RFSH;
                            r_we      <= 1'b0;
                            r_rfsh_rq <= 1'b1;
                        end else if (w_p0_pend) begin
                            r_job     <= c_JOB_P0;
                            r_we      <= 1'b0;
                            r_addr    <= p0_addr;
                            r_read_rq <= 1'b1;
                        end else begin
                            r_job      <= c_JOB_P1;
                            r_we       <= p1_we;
                            r_addr     <= p1_addr;
                            r_din      <= p1_wdata;
                            r_write_rq <= p1_we;
                            r_read_rq  <= !p1_we;
                        end
                    end
                end
                S_ISSUE: begin
                    if (ctl_busy) begin
                        r_read_rq  <= 1'b0;
                        r_write_rq <= 1'b0;
                        r_rfsh_rq  <= 1'b0;
                        r_state    <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!ctl_busy) begin
                        r_state <= S_IDLE;
                        if (r_job == c_JOB_P0) begin
                            r_p0_ack   <= 1'b1;
                            r_p0_rdata <= ctl_dout;
                        end else if (r_job == c_JOB_P1) begin
                            r_p1_ack <= 1'b1;
                            if (!r_we) begin
                                r_p1_rdata <= ctl_dout;
                            end
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_read_rq  <= 1'b0;
                    r_write_rq <= 1'b0;
                    r_rfsh_rq  <= 1'b0;
                end
            endcase
        end
    end

    assign p0_ack       = r_p0_ack;
    assign p0_rdata     = r_p0_rdata;
    assign p1_ack       = r_p1_ack;
    assign p1_rdata     = r_p1_rdata;
    assign ctl_addr     = r_addr;
    assign ctl_din      = r_din;
    assign ctl_read_rq  = r_read_rq;
    assign ctl_write_rq = r_write_rq;
    assign ctl_rfsh_rq  = r_rfsh_rq;

endmodule
`default_nettype wire
